// File: rtl/fir_seq_pkg.sv
// Shared types and constants for the FIR memory sequencer.
// Pure declarations: no latency, no backpressure.
package fir_seq_pkg;

  localparam int ADDR_W      = 8;
  localparam int RAM_DEPTH   = 1 << ADDR_W;
  localparam int LAT_DEFAULT = 6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_e;

endpackage

// File: rtl/valid_pipe.sv
// LAT-deep 1-bit shift register aligning read issue with the matching write.
// Latency LAT cycles din->tail; no backpressure, synchronous clear wins over din.
module valid_pipe
  import fir_seq_pkg::*;
#(
  parameter int LAT = LAT_DEFAULT
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  input  logic din,
  output logic tail
);

  logic [LAT-1:0] sr_q;
  logic [LAT-1:0] sr_d;

  always_comb begin
    sr_d = '0;
    if (!clr) begin
      sr_d[0] = din;
      for (int i = 1; i < LAT; i++) begin
        sr_d[i] = sr_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign tail = sr_q[LAT-1];

endmodule

// File: rtl/fir_mem_sequencer.sv
// Streams len+1 samples from the input RAM through the filter into the output RAM.
// Job takes len+LAT+2 cycles from start; no backpressure, start ignored while busy.
module fir_mem_sequencer #(
  parameter int ADDR_W   = 8,
  parameter int RD_LAT   = 1,
  parameter int FILT_LAT = 5
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] len,
  output logic              busy,
  output logic              done,
  output logic              in_nce,
  output logic              in_nwrt,
  output logic [ADDR_W-1:0] in_addr,
  output logic              out_nce,
  output logic              out_nwrt,
  output logic [ADDR_W-1:0] out_addr
);

  import fir_seq_pkg::*;

  localparam int LAT = RD_LAT + FILT_LAT;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   len_q, len_d;
  logic [ADDR_W-1:0]   rd_cnt_q, rd_cnt_d;
  logic [ADDR_W-1:0]   wr_cnt_q, wr_cnt_d;
  logic [ADDR_W-1:0]   out_addr_q, out_addr_d;
  logic                in_nce_q, in_nce_d;
  logic                out_nce_q, out_nce_d;
  logic                out_nwrt_q, out_nwrt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                rd_issue;
  logic                pipe_clr;
  logic                vld_tail;
  logic                last_rd;
  logic                last_wr;

  valid_pipe #(
    .LAT (LAT)
  ) u_valid_pipe (
    .clk  (clk),
    .rstn (rstn),
    .clr  (pipe_clr),
    .din  (rd_issue),
    .tail (vld_tail)
  );

  assign last_rd = (rd_cnt_q == len_q);
  // The final write is already on the bus when this is seen, so DONE follows it.
  assign last_wr = !out_nce_q && (out_addr_q == len_q);

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    rd_cnt_d   = rd_cnt_q;
    wr_cnt_d   = wr_cnt_q;
    out_addr_d = out_addr_q;
    in_nce_d   = 1'b1;
    out_nce_d  = 1'b1;
    out_nwrt_d = 1'b1;
    busy_d     = busy_q;
    done_d     = 1'b0;
    rd_issue   = 1'b0;
    pipe_clr   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_RUN;
          len_d    = len;
          rd_cnt_d = '0;
          in_nce_d = 1'b0;
          rd_issue = 1'b1;
          busy_d   = 1'b1;
        end
      end

      ST_RUN, ST_DRAIN: begin
        if (abort) begin
          state_d  = ST_IDLE;
          busy_d   = 1'b0;
          pipe_clr = 1'b1;
          rd_cnt_d = '0;
          wr_cnt_d = '0;
        end else begin
          if (state_q == ST_RUN) begin
            if (last_rd) begin
              state_d = ST_DRAIN;
            end else begin
              rd_cnt_d = rd_cnt_q + 1'b1;
              in_nce_d = 1'b0;
              rd_issue = 1'b1;
            end
          end

          if (vld_tail) begin
            out_nce_d  = 1'b0;
            out_nwrt_d = 1'b0;
            out_addr_d = wr_cnt_q;
            if (wr_cnt_q != len_q) begin
              wr_cnt_d = wr_cnt_q + 1'b1;
            end
          end

          if (state_q == ST_DRAIN && last_wr) begin
            state_d  = ST_DONE;
            done_d   = 1'b1;
            busy_d   = 1'b0;
            rd_cnt_d = '0;
            wr_cnt_d = '0;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
      out_addr_q <= '0;
      in_nce_q   <= 1'b1;
      out_nce_q  <= 1'b1;
      out_nwrt_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
      out_addr_q <= out_addr_d;
      in_nce_q   <= in_nce_d;
      out_nce_q  <= out_nce_d;
      out_nwrt_q <= out_nwrt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign in_nce   = in_nce_q;
  assign in_nwrt  = 1'b1;
  assign in_addr  = rd_cnt_q;
  assign out_nce  = out_nce_q;
  assign out_nwrt = out_nwrt_q;
  assign out_addr = out_addr_q;

endmodule
